// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch (I) and data (D) requesters onto one memory port
// Optional performance counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_ok,
  output logic [DATA_W-1:0]   iresp_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic                dreq_write,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_wdata,
  output logic                dresp_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_write,
  output logic [2:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_strobe,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ok,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_igrant,
  output logic [31:0]         perf_dgrant,
  output logic [31:0]         perf_iwait
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W/8-1:0] strobe_q, strobe_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                grant_d, grant_i;

  // D wins unless I has already watched STARVE_MAX consecutive D grants.
  assign grant_d = (state_q == IDLE) && dreq_valid && !(ireq_valid && (starve_q == STARVE_LIM));
  assign grant_i = (state_q == IDLE) && !grant_d && ireq_valid;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = BUSY_D;
          addr_d   = dreq_addr;
          write_d  = dreq_write;
          size_d   = dreq_size;
          strobe_d = dreq_strobe;
          wdata_d  = dreq_wdata;
          if (!ireq_valid)
            starve_d = '0;
          else if (starve_q != STARVE_LIM)
            starve_d = starve_q + 4'd1;
        end else if (grant_i) begin
          state_d  = BUSY_I;
          addr_d   = ireq_addr;
          write_d  = 1'b0;
          size_d   = 3'b011;
          strobe_d = '0;
          wdata_d  = '0;
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ok)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_valid  = (state_q != IDLE);
  assign mem_addr   = addr_q;
  assign mem_write  = write_q;
  assign mem_size   = size_q;
  assign mem_strobe = strobe_q;
  assign mem_wdata  = wdata_q;

  // Responses are steered combinationally so the owner sees data in the mem_ok cycle.
  assign iresp_ok   = (state_q == BUSY_I) && mem_ok;
  assign dresp_ok   = (state_q == BUSY_D) && mem_ok;
  assign iresp_data = iresp_ok ? mem_rdata : '0;
  assign dresp_data = dresp_ok ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] igrant_q, dgrant_q, iwait_q;
  logic        iwait_now;

  assign iwait_now = ireq_valid && (state_q != BUSY_I) && !grant_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      igrant_q <= '0;
      dgrant_q <= '0;
      iwait_q  <= '0;
    end else begin
      igrant_q <= igrant_q + {31'd0, grant_i};
      dgrant_q <= dgrant_q + {31'd0, grant_d};
      iwait_q  <= iwait_q + {31'd0, iwait_now};
    end
  end

  assign perf_igrant = igrant_q;
  assign perf_dgrant = dgrant_q;
  assign perf_iwait  = iwait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Exercises perf counters too when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq_valid;
  logic [AW-1:0] ireq_addr;
  logic          iresp_ok;
  logic [DW-1:0] iresp_data;
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic          dreq_write;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [DW-1:0] dreq_wdata;
  logic          dresp_ok;
  logic [DW-1:0] dresp_data;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [2:0]    mem_size;
  logic [7:0]    mem_strobe;
  logic [DW-1:0] mem_wdata;
  logic          mem_ok = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   perf_igrant, perf_dgrant, perf_iwait;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_size(mem_size), .mem_strobe(mem_strobe), .mem_wdata(mem_wdata),
    .mem_ok(mem_ok), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_igrant(perf_igrant), .perf_dgrant(perf_dgrant), .perf_iwait(perf_iwait)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          phase = 0;
  int          ok_delay = 0;
  logic        stray_ok = 1'b0;
  logic [63:0] rdata_base = '0;

  // Memory responder: acknowledges after ok_delay wait cycles, read data varies per cycle.
  int busy_n = 0;
  always @(posedge clk) begin
    #1;
    if (mem_valid) begin
      mem_ok    = (busy_n >= ok_delay) || stray_ok;
      mem_rdata = rdata_base + (64'(busy_n) << 8);
      busy_n++;
    end else begin
      busy_n    = 0;
      mem_ok    = stray_ok;
      mem_rdata = rdata_base;
    end
  end

  // Reference: who owns the port, the transaction it carries, and the fairness tally.
  int          m_owner = 0;
  int          m_starve = 0;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic        m_write = 1'b0;
  logic [2:0]  m_size = '0;
  logic [7:0]  m_strobe = '0;
  logic [31:0] m_ig = '0, m_dg = '0, m_iw = '0;
  logic        m_gi, m_gd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = 0; m_starve = 0; m_ig = '0; m_dg = '0; m_iw = '0;
    end else begin
      m_gd = (m_owner == 0) && dreq_valid && !(ireq_valid && m_starve == SM);
      m_gi = (m_owner == 0) && !m_gd && ireq_valid;
      if (ireq_valid && m_owner != 1 && !m_gi) m_iw++;
      if (m_gd) begin
        m_owner = 2; m_addr = dreq_addr; m_write = dreq_write; m_size = dreq_size;
        m_strobe = dreq_strobe; m_wdata = dreq_wdata; m_dg++;
        m_starve = ireq_valid ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
      end else if (m_gi) begin
        m_owner = 1; m_addr = ireq_addr; m_write = 1'b0; m_size = 3'b011;
        m_strobe = '0; m_wdata = '0; m_ig++; m_starve = 0;
      end else if (m_owner != 0 && mem_ok) begin
        m_owner = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int          last_phase = 0;
  int          pc = 0;
  int          n_i = 0, n_d = 0;
  logic [15:0] ord = '0;

  always @(negedge clk) begin
    if (phase != last_phase) begin
      last_phase = phase; pc = 0; n_i = 0; n_d = 0; ord = '0;
    end else begin
      pc++;
    end
    if (reset) begin
      chk("rst_mem_valid", 64'(mem_valid), 64'h0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_mem_write", 64'(mem_write), 64'h0);
      chk("rst_mem_size", 64'(mem_size), 64'h0);
      chk("rst_mem_strobe", 64'(mem_strobe), 64'h0);
      chk("rst_mem_wdata", mem_wdata, 64'h0);
      chk("rst_resp", 64'({iresp_ok, dresp_ok}), 64'h0);
    end else begin
      chk("mem_valid", 64'(mem_valid), 64'(m_owner != 0));
      if (m_owner != 0) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_write", 64'(mem_write), 64'(m_write));
        chk("mem_size", 64'(mem_size), 64'(m_size));
        chk("mem_strobe", 64'(mem_strobe), 64'(m_strobe));
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("iresp_ok", 64'(iresp_ok), 64'(m_owner == 1 && mem_ok));
      chk("iresp_data", iresp_data, (m_owner == 1 && mem_ok) ? mem_rdata : 64'h0);
      chk("dresp_ok", 64'(dresp_ok), 64'(m_owner == 2 && mem_ok));
      chk("dresp_data", dresp_data, (m_owner == 2 && mem_ok) ? mem_rdata : 64'h0);
`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_igrant", 64'(perf_igrant), 64'(m_ig));
      chk("perf_dgrant", 64'(perf_dgrant), 64'(m_dg));
      chk("perf_iwait", 64'(perf_iwait), 64'(m_iw));
`endif
      if (iresp_ok) begin n_i++; ord = {ord[14:0], 1'b1}; end
      if (dresp_ok) begin n_d++; ord = {ord[14:0], 1'b0}; end
      case (phase)
        1: begin
          if (pc == 1) begin
            chk("p1_iresp_ok", 64'(iresp_ok), 64'h1);
            chk("p1_iresp_data", iresp_data, 64'h13);
            chk("p1_mem_addr", mem_addr, 64'h8000_0000);
            chk("p1_mem_size", 64'(mem_size), 64'h3);
          end
          if (pc == 2) chk("p1_idle_valid", 64'(mem_valid), 64'h0);
        end
        2: begin
          if (pc == 1) begin
            chk("p2_dresp_ok", 64'(dresp_ok), 64'h1);
            chk("p2_iresp_ok", 64'(iresp_ok), 64'h0);
            chk("p2_mem_write", 64'(mem_write), 64'h1);
            chk("p2_mem_addr", mem_addr, 64'h100);
            chk("p2_mem_wdata", mem_wdata, 64'hDEAD);
            chk("p2_mem_strobe", 64'(mem_strobe), 64'hFF);
          end
          if (pc == 2) chk("p2_gap", 64'(mem_valid), 64'h0);
          if (pc == 3) begin
            chk("p2_iresp_ok", 64'(iresp_ok), 64'h1);
            chk("p2_i_addr", mem_addr, 64'h8000_0040);
            chk("p2_i_write", 64'(mem_write), 64'h0);
          end
          if (pc == 5) begin
            chk("p2_order", 64'(ord), 64'h1);
            chk("p2_count", 64'(n_i + n_d), 64'h2);
          end
        end
        4: begin
          if (pc >= 1 && pc <= 6) begin
            chk("p4_hold_valid", 64'(mem_valid), 64'h1);
            chk("p4_hold_addr", mem_addr, 64'h2000);
            chk("p4_dresp_ok", 64'(dresp_ok), 64'(pc == 6));
          end
          if (pc == 6) chk("p4_dresp_data", dresp_data, 64'h5A00);
          if (pc == 8) begin
            chk("p4_dresp_count", 64'(n_d), 64'h1);
            chk("p4_iresp_count", 64'(n_i), 64'h0);
          end
          if (pc == 10) chk("p4_stray_ok", 64'({mem_valid, iresp_ok, dresp_ok}), 64'h0);
        end
        5: begin
          if (pc == 1) chk("p5_busy_addr", mem_addr, 64'h4000);
          if (pc == 3) chk("p5_no_resp", 64'({mem_valid, iresp_ok}), 64'h0);
          if (pc == 4) begin
            chk("p5_iresp_ok", 64'(iresp_ok), 64'h1);
            chk("p5_iresp_data", iresp_data, 64'h77);
          end
          if (pc == 6) chk("p5_iresp_count", 64'(n_i), 64'h1);
        end
        7: begin
          if (pc == 20) begin
            chk("p7_grant_order", 64'(ord), 64'h0021);
            chk("p7_grant_count", 64'(n_i + n_d), 64'd10);
`ifdef MEM_ARB_PERF_CNT_EN
            chk("p7_perf_dgrant", 64'(perf_dgrant), 64'd8);
            chk("p7_perf_igrant", 64'(perf_igrant), 64'd2);
            chk("p7_perf_iwait", 64'(perf_iwait), 64'd16);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_write = 1'b0;
    dreq_size = '0; dreq_strobe = '0; dreq_wdata = '0;
    step(3);
    reset = 1'b0;
    step(2);

    phase = 1;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; rdata_base = 64'h13; ok_delay = 0;
    step(2); ireq_valid = 1'b0;
    step(3);

    phase = 2;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0040;
    dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 64'h100; dreq_wdata = 64'hDEAD;
    dreq_strobe = 8'hFF; dreq_size = 3'b011; rdata_base = 64'h21;
    step(2); dreq_valid = 1'b0;
    step(2); ireq_valid = 1'b0;
    step(2);

    phase = 4;
    dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 64'h2000; dreq_size = 3'b010;
    dreq_strobe = 8'h0F; dreq_wdata = 64'h0; rdata_base = 64'h5500; ok_delay = 5;
    step(3); dreq_valid = 1'b0; dreq_addr = 64'hBAD;
    step(6); stray_ok = 1'b1;
    step(2); stray_ok = 1'b0;
    step(1);

    phase = 5;
    ireq_valid = 1'b1; ireq_addr = 64'h4000; rdata_base = 64'h77; ok_delay = 10;
    step(2);
    #2 reset = 1'b1;
    step(1);
    reset = 1'b0; ok_delay = 0;
    step(2); ireq_valid = 1'b0;
    step(2);

    phase = 6;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);

    phase = 7;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_1000;
    dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 64'h300; dreq_wdata = 64'h1234;
    dreq_strobe = 8'hF0; dreq_size = 3'b011; rdata_base = 64'h99; ok_delay = 0;
    step(20); ireq_valid = 1'b0; dreq_valid = 1'b0;
    step(3);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
